// File: rtl/bmp180_pkg.sv
// bmp180_pkg: shared error-monitor defaults, channel map and sizing helper
package bmp180_pkg;
    localparam int CNT_SZ_DEF  = 5;
    localparam int THR_DEF     = 8;
    localparam int WIN_CLK_DEF = 50_000_000;
    localparam int CH_I2C_ACK  = 0;
    localparam int CH_CHIP_ID  = 1;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/err_ch.sv
// err_ch: one error channel - synchroniser, rising-edge event, total/window counters and flags
module err_ch import bmp180_pkg::*; #(
    parameter int CNT_SZ = CNT_SZ_DEF,
    parameter int THR    = THR_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              err_i,
    input  logic              clr_i,
    input  logic              win_end_i,
    output logic [CNT_SZ-1:0] cnt_o,
    output logic              fl_o,
    output logic              sat_o,
    output logic              alarm_o
);
    localparam logic [CNT_SZ-1:0] MAX   = '1;
    localparam logic [CNT_SZ-1:0] THR_V = CNT_SZ'(THR);
    logic s1_q, s2_q, prev_q, fl_q, fl_d, alarm_q, alarm_d, ev;
    logic [CNT_SZ-1:0] cnt_q, cnt_d, win_q, win_d;
    always_comb begin
        ev      = s2_q & ~prev_q;
        cnt_d   = clr_i ? '0 : (ev && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
        // an event on the window-end cycle opens the new window at 1
        win_d   = clr_i ? '0 : win_end_i ? CNT_SZ'(ev) : (ev && win_q != THR_V) ? win_q + 1'b1 : win_q;
        fl_d    = ~clr_i & (fl_q | ev);
        alarm_d = ~clr_i & (alarm_q | (win_d == THR_V));
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            win_q   <= '0;
            fl_q    <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            s1_q    <= err_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            fl_q    <= fl_d;
            alarm_q <= alarm_d;
        end
    end
    assign cnt_o   = cnt_q;
    assign fl_o    = fl_q;
    assign sat_o   = cnt_q == MAX;
    assign alarm_o = alarm_q;
endmodule

// File: rtl/err_monitor.sv
// err_monitor: per-channel error event counters with rate alarm, shared window timer and read port
module err_monitor import bmp180_pkg::*; #(
    parameter int CH_N    = 4,
    parameter int CNT_SZ  = CNT_SZ_DEF,
    parameter int WIN_CLK = WIN_CLK_DEF,
    parameter int THR     = THR_DEF,
    localparam int RD_W   = clog2_min1(CH_N)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CH_N-1:0]   I_ERR,
    input  logic              I_CLR,
    input  logic [CH_N-1:0]   I_CLR_MSK,
    input  logic              I_RD_EN,
    input  logic [RD_W-1:0]   I_RD_CH,
    output logic [CNT_SZ-1:0] O_RD_CNT,
    output logic              O_RD_VLD,
    output logic [CH_N-1:0]   O_FL,
    output logic [CH_N-1:0]   O_SAT,
    output logic [CH_N-1:0]   O_ALARM
);
    localparam int WT_W = clog2_min1(WIN_CLK);
    logic [WT_W-1:0] wt_q, wt_d;
    logic win_end;
    logic [CNT_SZ-1:0] cnt_w [CH_N];
    logic [CNT_SZ-1:0] sel, rd_cnt_q, rd_cnt_d;
    logic rd_vld_q;
    always_comb begin
        win_end  = wt_q == WT_W'(WIN_CLK - 1);
        wt_d     = win_end ? '0 : wt_q + 1'b1;
        // out-of-range channels fall through to zero
        sel      = '0;
        for (int i = 0; i < CH_N; i++) sel = (I_RD_CH == RD_W'(i)) ? cnt_w[i] : sel;
        rd_cnt_d = I_RD_EN ? sel : rd_cnt_q;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wt_q     <= '0;
            rd_cnt_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            wt_q     <= wt_d;
            rd_cnt_q <= rd_cnt_d;
            rd_vld_q <= I_RD_EN;
        end
    end
    for (genvar g = 0; g < CH_N; g++) begin : g_ch
        err_ch #(.CNT_SZ(CNT_SZ), .THR(THR)) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .err_i     (I_ERR[g]),
            .clr_i     (I_CLR & I_CLR_MSK[g]),
            .win_end_i (win_end),
            .cnt_o     (cnt_w[g]),
            .fl_o      (O_FL[g]),
            .sat_o     (O_SAT[g]),
            .alarm_o   (O_ALARM[g])
        );
    end
    assign O_RD_CNT = rd_cnt_q;
    assign O_RD_VLD = rd_vld_q;
endmodule

// File: tb/tb_err_monitor.sv
// tb_err_monitor: directed checks of err_monitor with CH_N=3, CNT_SZ=3, WIN_CLK=20, THR=3
module tb_err_monitor;
    logic CLK, RST, I_CLR, I_RD_EN, O_RD_VLD;
    logic [2:0] I_ERR, I_CLR_MSK, O_FL, O_SAT, O_ALARM, O_RD_CNT;
    logic [1:0] I_RD_CH;
    int checks = 0, errors = 0, cyc = 0;
    logic v;
    logic [2:0] n;

    err_monitor #(.CH_N(3), .CNT_SZ(3), .WIN_CLK(20), .THR(3)) dut (
        .CLK(CLK), .RST(RST), .I_ERR(I_ERR), .I_CLR(I_CLR), .I_CLR_MSK(I_CLR_MSK),
        .I_RD_EN(I_RD_EN), .I_RD_CH(I_RD_CH), .O_RD_CNT(O_RD_CNT), .O_RD_VLD(O_RD_VLD),
        .O_FL(O_FL), .O_SAT(O_SAT), .O_ALARM(O_ALARM)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        #4;
        RST = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse(input int ch);
        I_ERR[ch] = 1'b1;
        tick();
        I_ERR[ch] = 1'b0;
        tick();
    endtask

    task automatic pulse_at(input int ch, input int e);
        while (cyc < e - 1) tick();
        pulse(ch);
    endtask

    task automatic rd(input logic [1:0] c, output logic vo, output logic [2:0] no);
        I_RD_EN = 1'b1;
        I_RD_CH = c;
        tick();
        vo = O_RD_VLD;
        no = O_RD_CNT;
        I_RD_EN = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        repeat (5) pulse(1);
        tick();
        I_ERR[0] = 1'b1;
        tick();
        tick();
        rd(2'd1, v, n);
        checks++;
        if (n !== 3'd5) begin errors++; $display("FAIL pre_rst_cnt: got %0d want 5", n); end
        checks++;
        if (O_ALARM !== 3'b010 || O_FL !== 3'b011) begin errors++; $display("FAIL pre_rst_flags: alarm %b fl %b want 010 011", O_ALARM, O_FL); end
        RST = 1'b1;
        #1;
        checks++;
        if ({O_FL, O_SAT, O_ALARM} !== 9'd0) begin errors++; $display("FAIL rst_flags: fl %b sat %b alarm %b want 0", O_FL, O_SAT, O_ALARM); end
        checks++;
        if (O_RD_VLD !== 1'b0 || O_RD_CNT !== 3'd0) begin errors++; $display("FAIL rst_rd: vld %b cnt %0d want 0 0", O_RD_VLD, O_RD_CNT); end
        #3;
        RST = 1'b0;
        cyc = 0;
        tick();
        tick();
        checks++;
        if (O_FL !== 3'b000) begin errors++; $display("FAIL fl_early: got %b want 000", O_FL); end
        tick();
        checks++;
        if (O_FL !== 3'b001) begin errors++; $display("FAIL fl_k2: got %b want 001", O_FL); end
        repeat (10) tick();
        rd(2'd0, v, n);
        checks++;
        if (n !== 3'd1) begin errors++; $display("FAIL level_once: got %0d want 1", n); end
        I_ERR = 3'b000;
    endtask

    task automatic test_sat;
        do_reset();
        repeat (6) pulse(1);
        tick();
        checks++;
        if (O_SAT !== 3'b000) begin errors++; $display("FAIL sat_early: got %b want 000", O_SAT); end
        rd(2'd1, v, n);
        checks++;
        if (n !== 3'd6) begin errors++; $display("FAIL cnt6: got %0d want 6", n); end
        repeat (3) pulse(1);
        tick();
        checks++;
        if (O_SAT !== 3'b010) begin errors++; $display("FAIL sat_set: got %b want 010", O_SAT); end
        rd(2'd1, v, n);
        checks++;
        if (n !== 3'd7) begin errors++; $display("FAIL sat_nowrap: got %0d want 7", n); end
        checks++;
        if (O_ALARM !== 3'b010) begin errors++; $display("FAIL sat_alarm: got %b want 010", O_ALARM); end
        I_CLR = 1'b1;
        I_CLR_MSK = 3'b010;
        tick();
        I_CLR = 1'b0;
        checks++;
        if ({O_FL, O_SAT, O_ALARM} !== 9'd0) begin errors++; $display("FAIL clr_flags: fl %b sat %b alarm %b want 0", O_FL, O_SAT, O_ALARM); end
        rd(2'd1, v, n);
        checks++;
        if (n !== 3'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", n); end
    endtask

    task automatic test_alarm;
        do_reset();
        pulse_at(1, 1);
        pulse_at(1, 3);
        pulse_at(1, 5);
        checks++;
        if (O_ALARM !== 3'b000) begin errors++; $display("FAIL alarm_2ev: got %b want 000", O_ALARM); end
        tick();
        checks++;
        if (O_ALARM !== 3'b010) begin errors++; $display("FAIL alarm_3ev: got %b want 010", O_ALARM); end
    endtask

    task automatic test_window_3;
        do_reset();
        for (int b = 0; b < 60; b += 20) begin
            pulse_at(0, b + 1);
            pulse_at(0, b + 3);
        end
        while (cyc < 62) tick();
        checks++;
        if (O_ALARM !== 3'b000) begin errors++; $display("FAIL win_2per: got %b want 000", O_ALARM); end
        rd(2'd0, v, n);
        checks++;
        if (n !== 3'd6) begin errors++; $display("FAIL win_total: got %0d want 6", n); end
    endtask

    task automatic test_window_edge;
        do_reset();
        pulse_at(2, 14);
        pulse_at(2, 16);
        pulse_at(2, 18);
        pulse_at(2, 20);
        tick();
        checks++;
        if (O_ALARM !== 3'b000) begin errors++; $display("FAIL win_edge_new: got %b want 000", O_ALARM); end
        pulse_at(2, 22);
        tick();
        checks++;
        if (O_ALARM !== 3'b100) begin errors++; $display("FAIL win_edge_cnt: got %b want 100", O_ALARM); end
    endtask

    task automatic test_clear;
        do_reset();
        pulse(0);
        pulse(0);
        pulse(1);
        tick();
        I_ERR = 3'b011;
        tick();
        I_ERR = 3'b000;
        tick();
        I_CLR = 1'b1;
        I_CLR_MSK = 3'b001;
        I_RD_EN = 1'b1;
        I_RD_CH = 2'd1;
        tick();
        I_CLR = 1'b0;
        I_RD_EN = 1'b0;
        checks++;
        if (O_RD_VLD !== 1'b1 || O_RD_CNT !== 3'd1) begin errors++; $display("FAIL rd_pre_inc: vld %b cnt %0d want 1 1", O_RD_VLD, O_RD_CNT); end
        checks++;
        if (O_FL !== 3'b010) begin errors++; $display("FAIL clr_fl: got %b want 010", O_FL); end
        rd(2'd0, v, n);
        checks++;
        if (n !== 3'd0) begin errors++; $display("FAIL clr_wins: got %0d want 0", n); end
        rd(2'd1, v, n);
        checks++;
        if (n !== 3'd2) begin errors++; $display("FAIL clr_unmasked: got %0d want 2", n); end
    endtask

    task automatic test_back_to_back;
        I_RD_EN = 1'b1;
        I_RD_CH = 2'd1;
        tick();
        checks++;
        if (O_RD_VLD !== 1'b1 || O_RD_CNT !== 3'd2) begin errors++; $display("FAIL b2b_0: vld %b cnt %0d want 1 2", O_RD_VLD, O_RD_CNT); end
        I_RD_CH = 2'd3;
        tick();
        checks++;
        if (O_RD_VLD !== 1'b1 || O_RD_CNT !== 3'd0) begin errors++; $display("FAIL b2b_oor: vld %b cnt %0d want 1 0", O_RD_VLD, O_RD_CNT); end
        I_RD_CH = 2'd1;
        tick();
        checks++;
        if (O_RD_VLD !== 1'b1 || O_RD_CNT !== 3'd2) begin errors++; $display("FAIL b2b_2: vld %b cnt %0d want 1 2", O_RD_VLD, O_RD_CNT); end
        I_RD_EN = 1'b0;
        tick();
        checks++;
        if (O_RD_VLD !== 1'b0) begin errors++; $display("FAIL b2b_end: vld %b want 0", O_RD_VLD); end
    endtask

    initial begin
        RST = 1'b1;
        I_ERR = 3'b000;
        I_CLR = 1'b0;
        I_CLR_MSK = 3'b000;
        I_RD_EN = 1'b0;
        I_RD_CH = 2'd0;
        @(posedge CLK);
        #1;
        test_reset();
        test_sat();
        test_alarm();
        test_window_3();
        test_window_edge();
        test_clear();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
